// File: rtl/dataram_wr_sched.sv
// Write-slot scheduler for the 8 shared data RAMs (W/E/S/N/LF requesters).
// Optional starvation promotion: define DATARAM_WR_SCHED_STARVE_EN.
module dataram_wr_sched #(
    parameter int unsigned SHIFT_W    = 20,
    parameter int unsigned CMD_DLY_W  = 2,
    parameter int unsigned CMD_DLY_E  = 3,
    parameter int unsigned CMD_DLY_S  = 4,
    parameter int unsigned CMD_DLY_N  = 5,
    parameter int unsigned CMD_DLY_LF = 1,
    parameter int unsigned STARVE_LIM = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              req_vld,
    input  logic [14:0]             req_ram_sel,
    output logic [4:0]              req_rdy,
    output logic [7:0][SHIFT_W-1:0] ram_rsv,
    output logic [7:0]              ram_wr_slot,
    output logic [2:0]              gnt_cnt
);
    localparam int unsigned NREQ = 5;
    localparam int unsigned IW   = $clog2(SHIFT_W);

    function automatic int unsigned cmd_dly(input int unsigned r);
        case (r)
            0:       return CMD_DLY_W;
            1:       return CMD_DLY_E;
            2:       return CMD_DLY_S;
            3:       return CMD_DLY_N;
            default: return CMD_DLY_LF;
        endcase
    endfunction

    function automatic int unsigned max_dly();
        int unsigned m;
        m = 0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (cmd_dly(r) > m) m = cmd_dly(r);
        end
        return m;
    endfunction

    localparam int unsigned MAX_DLY = max_dly();

    if (MAX_DLY + 9 > SHIFT_W) begin : g_bad_shift_w
        $error("dataram_wr_sched: SHIFT_W too small for the largest CMD_DLY");
    end
    if (STARVE_LIM > 15) begin : g_bad_starve_lim
        $error("dataram_wr_sched: STARVE_LIM must fit the 4-bit wait counter");
    end

    logic [7:0][SHIFT_W-1:0] rsv_q;
    logic [7:0][SHIFT_W-1:0] set_bits;
    logic [2:0]              rr_q;
    logic [2:0]              rr_d;
    logic [2:0]              sel_a [NREQ];
    logic [IW-1:0]           idx_a [NREQ];
    logic [IW-1:0]           chk_a [NREQ];
    logic [NREQ-1:0]         promote;
    logic [2:0]              cur_r;
    logic [2:0]              last_r;
    logic                    cand;
    logic                    any_gnt;

    always_comb begin
        for (int unsigned r = 0; r < NREQ; r++) begin
            sel_a[r] = req_ram_sel[3*r +: 3];
            idx_a[r] = IW'(cmd_dly(r) + 8 - 32'(sel_a[r][2:1]));
            // Register shifts before the new bit lands, so the slot is checked one position up.
            chk_a[r] = IW'(cmd_dly(r) + 9 - 32'(sel_a[r][2:1]));
        end
    end

    // Pass 0..4 visits promoted requesters by index, pass 5..9 the rest in round-robin order.
    always_comb begin
        req_rdy  = '0;
        set_bits = '0;
        last_r   = rr_q;
        any_gnt  = 1'b0;
        cur_r    = '0;
        cand     = 1'b0;
        for (int unsigned p = 0; p < 2 * NREQ; p++) begin
            if (p < NREQ) begin
                cur_r = 3'(p);
                cand  = promote[cur_r];
            end else begin
                cur_r = 3'((32'(rr_q) + p - NREQ) % NREQ);
                cand  = !promote[cur_r];
            end
            if (cand && rst_n && req_vld[cur_r] &&
                !rsv_q[sel_a[cur_r]][chk_a[cur_r]] &&
                !set_bits[sel_a[cur_r]][idx_a[cur_r]]) begin
                req_rdy[cur_r]                       = 1'b1;
                set_bits[sel_a[cur_r]][idx_a[cur_r]] = 1'b1;
                last_r                               = cur_r;
                any_gnt                              = 1'b1;
            end
        end
        if (!any_gnt) begin
            rr_d = rr_q;
        end else if (last_r == 3'(NREQ - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = last_r + 3'd1;
        end
    end

    always_comb begin
        gnt_cnt = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            gnt_cnt = gnt_cnt + 3'(req_rdy[r]);
        end
        for (int unsigned i = 0; i < 8; i++) begin
            ram_wr_slot[i] = rsv_q[i][0];
        end
    end

    assign ram_rsv = rsv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsv_q <= '0;
            rr_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                rsv_q[i] <= (rsv_q[i] >> 1) | set_bits[i];
            end
            rr_q <= rr_d;
        end
    end

`ifdef DATARAM_WR_SCHED_STARVE_EN
    logic [NREQ-1:0][3:0] wait_q;

    always_comb begin
        for (int unsigned r = 0; r < NREQ; r++) begin
            promote[r] = (wait_q[r] >= 4'(STARVE_LIM));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (req_vld[r] && !req_rdy[r]) begin
                    if (wait_q[r] != 4'hf) wait_q[r] <= wait_q[r] + 4'd1;
                end else begin
                    wait_q[r] <= '0;
                end
            end
        end
    end
`else
    assign promote = '0;
`endif

endmodule

// File: tb/tb_dataram_wr_sched.sv
// Scoreboard bench for dataram_wr_sched: expected RAM write slots are queued at grant
// time and compared every cycle against ram_wr_slot.
module tb_dataram_wr_sched;
    localparam int unsigned SHIFT_W = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]              req_vld;
    logic [14:0]             req_ram_sel;
    logic [4:0]              req_rdy;
    logic [7:0][SHIFT_W-1:0] ram_rsv;
    logic [7:0]              ram_wr_slot;
    logic [2:0]              gnt_cnt;

    logic [4:0]              rr_vld;
    logic [14:0]             rr_sel;
    logic [4:0]              rr_rdy;
    logic [7:0][SHIFT_W-1:0] rr_rsv;
    logic [7:0]              rr_wr_slot;
    logic [2:0]              rr_gnt_cnt;

    dataram_wr_sched #(
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_ram_sel (req_ram_sel),
        .req_rdy     (req_rdy),
        .ram_rsv     (ram_rsv),
        .ram_wr_slot (ram_wr_slot),
        .gnt_cnt     (gnt_cnt)
    );

    // W and E share a delay here, so same-RAM requests collide on the same slot.
    dataram_wr_sched #(
        .SHIFT_W    (SHIFT_W),
        .CMD_DLY_W  (3),
        .CMD_DLY_E  (3),
        .STARVE_LIM (3)
    ) dut_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (rr_vld),
        .req_ram_sel (rr_sel),
        .req_rdy     (rr_rdy),
        .ram_rsv     (rr_rsv),
        .ram_wr_slot (rr_wr_slot),
        .gnt_cnt     (rr_gnt_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int ram;
        int due;
    } slot_t;
    slot_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int dly(input int r);
        case (r)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            3:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic logic [14:0] sel_of(input int r, input int s);
        logic [14:0] v;
        v = 15'(s);
        return v << (3 * r);
    endfunction

    task automatic push_slot(input int r, input int s);
        slot_t e;
        e.ram = s;
        e.due = cyc + dly(r) + 8 - (s / 2) + 1;
        sb.push_back(e);
    endtask

    logic [7:0] exp_slot;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_slot = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    exp_slot[sb[i].ram] = 1'b1;
                    sb.delete(i);
                end
            end
            check("wr_slot", 32'(ram_wr_slot), 32'(exp_slot));
        end
    end

    task automatic drive(input logic [4:0] v, input logic [14:0] s);
        @(negedge clk);
        req_vld     = v;
        req_ram_sel = s;
        #1;
    endtask

    task automatic rdrive(input logic [4:0] v, input logic [14:0] s);
        @(negedge clk);
        rr_vld = v;
        rr_sel = s;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(5'b0, 15'b0);
    endtask

    task automatic do_reset(input logic [4:0] v);
        @(negedge clk);
        rst_n   = 1'b0;
        req_vld = v;
        rr_vld  = v;
        #1;
        check("rst_rdy", 32'(req_rdy), 32'h0);
        check("rst_gnt_cnt", 32'(gnt_cnt), 32'h0);
        check("rst_rr_rdy", 32'(rr_rdy), 32'h0);
        @(posedge clk);
        sb.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        req_vld = '0;
        rr_vld  = '0;
        #1;
        check("rst_rsv_zero", 32'(|ram_rsv), 32'h0);
    endtask

    logic [14:0] par_sel;
    logic        got_w;

    initial begin
        rst_n       = 1'b0;
        req_vld     = '0;
        req_ram_sel = '0;
        rr_vld      = '0;
        rr_sel      = '0;
        repeat (2) @(posedge clk);
        do_reset(5'h1f);
        mon_en = 1'b1;

        // Single grant, W to RAM 0: slot idx 10, write 11 cycles later.
        drive(5'b00001, sel_of(0, 0));
        check("single_rdy", 32'(req_rdy), 32'h01);
        check("single_cnt", 32'(gnt_cnt), 32'h1);
        push_slot(0, 0);
        drive(5'b0, 15'b0);
        check("single_rsv", 32'(ram_rsv[0]), 32'h400);
        idle(14);

        // Reservation stall: E then W to RAM 4.
        drive(5'b00010, sel_of(1, 4));
        check("stall_e_rdy", 32'(req_rdy), 32'h02);
        push_slot(1, 4);
        drive(5'b00001, sel_of(0, 4));
        check("stall_w_blocked", 32'(req_rdy), 32'h00);
        check("stall_cnt0", 32'(gnt_cnt), 32'h0);
        check("stall_rsv", 32'(ram_rsv[4]), 32'h200);
        drive(5'b00001, sel_of(0, 4));
        check("stall_w_rdy", 32'(req_rdy), 32'h01);
        push_slot(0, 4);
        drive(5'b0, sel_of(0, 4));
        check("no_vld_no_rdy", 32'(req_rdy), 32'h00);
        idle(14);

        // Parallel: every requester to its own RAM.
        par_sel = sel_of(0, 0) | sel_of(1, 1) | sel_of(2, 2) | sel_of(3, 3) | sel_of(4, 4);
        drive(5'h1f, par_sel);
        check("par_rdy", 32'(req_rdy), 32'h1f);
        check("par_cnt", 32'(gnt_cnt), 32'h5);
        for (int r = 0; r < 5; r++) push_slot(r, r);
        idle(16);

        // Reset mid-flight: the granted write must never reach the RAM.
        drive(5'b00001, sel_of(0, 2));
        check("mid_rdy", 32'(req_rdy), 32'h01);
        idle(2);
        do_reset(5'b0);
        idle(16);

        // Round-robin instance: parallel first so rr_ptr must come back to 0.
        rdrive(5'h1f, par_sel);
        check("rr_par_rdy", 32'(rr_rdy), 32'h1f);
        check("rr_par_cnt", 32'(rr_gnt_cnt), 32'h5);
        rdrive(5'b0, 15'b0);
        rdrive(5'b0, 15'b0);
        for (int k = 0; k < 4; k++) begin
            rdrive(5'b00011, sel_of(0, 1) | sel_of(1, 1));
            check("rr_tie_rdy", 32'(rr_rdy), (k % 2 == 0) ? 32'h01 : 32'h02);
            check("rr_tie_cnt", 32'(rr_gnt_cnt), 32'h1);
        end
`ifdef DATARAM_WR_SCHED_STARVE_EN
        got_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rdrive(5'b00011, sel_of(0, 1) | sel_of(1, 1));
            if (rr_rdy[0]) got_w = 1'b1;
        end
        check("starve_w_gnt", 32'(got_w), 32'h1);
`else
        got_w = 1'b0;
`endif
        rdrive(5'b0, 15'b0);
        idle(20);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

endmodule
